// File: rtl/mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_seq_ctrl
// Multi-cycle sequencer for the EX-stage multiply/divide unit. Accepts
// MULT/MULTU/DIV/DIVU, stalls the front of the pipeline while the operation
// is in flight, and presents {hi,lo} with a one-cycle HILO write strobe.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   start_i    in   EX holds a mul/div op (sampled only in IDLE)
//   op_i       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i   in   rs / rt operands
//   cancel_i   in   EX flush; aborts the operation or suppresses the strobe
//   stall_o    out  freezes IF/ID/EX while the op is in flight
//   busy_o     out  state is MUL or DIV
//   done_o     out  one-cycle result pulse
//   hilo_we_o  out  HILO write enable (same as done_o)
//   hi_o, lo_o out  product halves or remainder/quotient
// ---------------------------------------------------------------------------
module mdu_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             isSigned;
    // opA/opB hold the multiply operands; for a divide opA is the dividend /
    // quotient shift register and opB the divisor magnitude.
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] remReg;
    logic             quoNeg;
    logic             remNeg;

    logic             inSigned;
    logic [WIDTH-1:0] aAbs;
    logic [WIDTH-1:0] bAbs;
    logic [2*WIDTH-1:0] extA;
    logic [2*WIDTH-1:0] extB;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] quoFinal;
    logic [WIDTH-1:0] remFinal;

    always_comb begin
        inSigned = ~op_i[0];
        aAbs = (inSigned && a_i[WIDTH-1]) ? -a_i : a_i;
        bAbs = (inSigned && b_i[WIDTH-1]) ? -b_i : b_i;

        // Sign- or zero-extend to 2*WIDTH so one unsigned multiply serves both.
        extA = isSigned ? {{WIDTH{opA[WIDTH-1]}}, opA} : {{WIDTH{1'b0}}, opA};
        extB = isSigned ? {{WIDTH{opB[WIDTH-1]}}, opB} : {{WIDTH{1'b0}}, opB};
        product = extA * extB;

        // One restoring-division step: shift in the next dividend bit, try subtract.
        trial = {remReg, opA[WIDTH-1]} - {1'b0, opB};
        if (!trial[WIDTH]) begin
            remNext = trial[WIDTH-1:0];
            quoNext = {opA[WIDTH-2:0], 1'b1};
        end else begin
            remNext = {remReg[WIDTH-2:0], opA[WIDTH-1]};
            quoNext = {opA[WIDTH-2:0], 1'b0};
        end
        quoFinal = quoNeg ? -quoNext : quoNext;
        remFinal = remNeg ? -remNext : remNext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            isSigned <= 1'b0;
            opA      <= '0;
            opB      <= '0;
            remReg   <= '0;
            quoNeg   <= 1'b0;
            remNeg   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !cancel_i) begin
                        isSigned <= inSigned;
                        cnt      <= '0;
                        remReg   <= '0;
                        if (!op_i[1]) begin
                            opA   <= a_i;
                            opB   <= b_i;
                            state <= MUL;
                        end else if (b_i == '0) begin
                            hi_o  <= a_i;
                            lo_o  <= '1;
                            state <= DONE;
                        end else begin
                            opA    <= aAbs;
                            opB    <= bAbs;
                            quoNeg <= inSigned & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            remNeg <= inSigned & a_i[WIDTH-1];
                            state  <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (cancel_i) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == MUL_LAST) begin
                        hi_o  <= product[2*WIDTH-1:WIDTH];
                        lo_o  <= product[WIDTH-1:0];
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (cancel_i) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        opA    <= quoNext;
                        remReg <= remNext;
                        if (cnt == DIV_LAST) begin
                            lo_o  <= quoFinal;
                            hi_o  <= remFinal;
                            cnt   <= '0;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o    = (state == MUL) || (state == DIV);
        stall_o   = ((state == IDLE) && start_i && !cancel_i) || busy_o;
        done_o    = (state == DONE) && !cancel_i;
        hilo_we_o = done_o;
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_seq_ctrl
// Self-checking bench for mdu_seq_ctrl: directed cases, cancel/reset cases,
// and randomized operations compared against a 64-bit arithmetic model.
// ---------------------------------------------------------------------------
module tb_mdu_seq_ctrl;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cancel_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int nAssert;
    int nFail;
    int weCount = 0;
    int expWe;

    mdu_seq_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .cancel_i  (cancel_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hilo_we_o (hilo_we_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hilo_we_o === 1'b1) weCount++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic (truncating division).
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint      sp;
        logic [63:0] r;
        case (op)
            2'b00: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                r  = sp;
                hi = r[63:32]; lo = r[31:0];
            end
            2'b01: begin
                r  = {32'b0, a} * {32'b0, b};
                hi = r[63:32]; lo = r[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    sp = longint'($signed(a)) / longint'($signed(b));
                    r  = sp; lo = r[31:0];
                    sp = longint'($signed(a)) % longint'($signed(b));
                    r  = sp; hi = r[31:0];
                end else begin
                    r  = {32'b0, a} / {32'b0, b}; lo = r[31:0];
                    r  = {32'b0, a} % {32'b0, b}; hi = r[31:0];
                end
            end
        endcase
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input bit holdStart);
        int cycles;
        int expLat;
        bit stallOk;
        bit seenDone;
        expLat = op[1] ? ((b == 32'd0) ? 1 : WIDTH + 1) : MUL_LAT + 1;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; cancel_i = 1'b0;
        #1;
        check("idleBeforeAccept", 64'(busy_o), 64'(0));
        check("stallAccept", 64'(stall_o), 64'(1));
        cycles = 0; stallOk = 1'b1; seenDone = 1'b0;
        while (!seenDone && cycles < 100) begin
            @(negedge clk);
            cycles++;
            start_i = holdStart;
            op_i = 2'($urandom);
            a_i = $urandom;
            b_i = $urandom;
            #1;
            if (done_o === 1'b1) seenDone = 1'b1;
            else if (!(stall_o === 1'b1 && busy_o === 1'b1)) stallOk = 1'b0;
        end
        check("doneSeen", 64'(seenDone), 64'(1));
        check("latency", 64'(cycles), 64'(expLat));
        check("stallWhileBusy", 64'(stallOk), 64'(1));
        check("hi", 64'(hi_o), 64'(expHi));
        check("lo", 64'(lo_o), 64'(expLo));
        check("weInDone", 64'(hilo_we_o), 64'(1));
        check("stallInDone", 64'(stall_o), 64'(0));
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("singlePulse", 64'(done_o | hilo_we_o), 64'(0));
        check("idleAfterDone", 64'(busy_o), 64'(0));
        check("hiHold", 64'(hi_o), 64'(expHi));
        if (seenDone) expWe++;
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        logic [31:0] eHi;
        logic [31:0] eLo;
        bit          okFlag;
        bit          stallFlag;
        int          pick;

        nAssert = 0; nFail = 0; expWe = 0;
        rst = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0; cancel_i = 1'b0;

        #2;
        check("rstHi", 64'(hi_o), 64'(0));
        check("rstLo", 64'(lo_o), 64'(0));
        check("rstFlags", 64'({stall_o, busy_o, done_o, hilo_we_o}), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Directed arithmetic cases
        runOp(2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        runOp(2'b01, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        runOp(2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0);
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0);
        runOp(2'b10, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b0);
        runOp(2'b11, 32'd9,         32'd0,        32'd9,         32'hFFFF_FFFF, 1'b0);
        // start_i held through DONE
        runOp(2'b00, 32'd3,         32'd4,        32'd0,         32'd12,        1'b1);

        // DIVU cancelled at T+10, new MULT accepted at T+11
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; a_i = 32'd1000; b_i = 32'd3; #1;
        check("cancelAccept", 64'(stall_o), 64'(1));
        okFlag = 1'b1; stallFlag = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            cancel_i = (i == 10);
            #1;
            if (done_o !== 1'b0 || hilo_we_o !== 1'b0) okFlag = 1'b0;
            if (stall_o !== 1'b1) stallFlag = 1'b0;
        end
        check("cancelNoWe", 64'(okFlag), 64'(1));
        check("cancelStall", 64'(stallFlag), 64'(1));
        runOp(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0);

        // cancel during DONE of a divide-by-zero suppresses the strobe
        @(negedge clk);
        cancel_i = 1'b0; start_i = 1'b1; op_i = 2'b10; a_i = 32'd9; b_i = 32'd0; #1;
        @(negedge clk);
        start_i = 1'b0; cancel_i = 1'b1; #1;
        check("cancelDoneStrobe", 64'({done_o, hilo_we_o}), 64'(0));
        check("cancelDoneStall", 64'(stall_o), 64'(0));
        check("cancelDoneHi", 64'(hi_o), 64'(9));
        @(negedge clk);
        cancel_i = 1'b0; #1;
        check("cancelDoneIdle", 64'({busy_o, done_o}), 64'(0));

        // start with cancel in IDLE: not accepted
        @(negedge clk);
        start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b00; #1;
        check("startCancelStall", 64'(stall_o), 64'(0));
        @(negedge clk);
        start_i = 1'b0; cancel_i = 1'b0; #1;
        check("startCancelNoAccept", 64'({busy_o, done_o}), 64'(0));

        // Randomized operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            rOp = 2'($urandom_range(0, 3));
            rA = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0)      rB = 32'd0;
            else if (pick == 1) rB = 32'hFFFF_FFFF;
            else if (pick == 2) rB = 32'($urandom_range(1, 15));
            else                rB = $urandom;
            model(rOp, rA, rB, eHi, eLo);
            runOp(rOp, rA, rB, eHi, eLo, 1'b0);
        end

        // Async reset pulse mid-DIV, after a known nonzero result
        runOp(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd12345; b_i = 32'd67; #1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midRstFlags", 64'({stall_o, busy_o, done_o, hilo_we_o}), 64'(0));
        check("midRstHi", 64'(hi_o), 64'(0));
        check("midRstLo", 64'(lo_o), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("postRstIdle", 64'({busy_o, done_o}), 64'(0));

        check("weTotal", 64'(weCount), 64'(expWe));

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
